// File: rtl/cmd_framer.sv
// Two-byte command framer between a UART receiver and its consumer, plus
// acknowledge-byte transmit sequencing. Optional inter-byte timeout: CMD_TMO_EN.
module cmd_framer #(
    parameter int unsigned TMO_CYC   = 1_000_000,
    parameter logic [7:0]  RESP_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp
);

    typedef enum logic {HIGH, LOW} state_t;

    state_t state;
    logic   tx_busy;
    logic   resp_pend;
    logic   busy_eff;

    assign tx_data = RESP_BYTE;

    // Every byte is consumed in the cycle it is seen, in either state.
    assign clr_rx_rdy = rx_rdy & rst_n;

`ifdef CMD_TMO_EN
    localparam int unsigned CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [CW-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HIGH;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
`ifdef CMD_TMO_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                HIGH: begin
                    if (rx_rdy) begin
                        cmd[15:8] <= rx_data;
                        cmd_rdy   <= 1'b0;
                        state     <= LOW;
`ifdef CMD_TMO_EN
                        tmo_cnt   <= '0;
`endif
                    end else if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                    end
                end
                LOW: begin
                    if (clr_cmd_rdy)
                        cmd_rdy <= 1'b0;
                    // Later assignment lets completion win over a coincident clear.
                    if (rx_rdy) begin
                        cmd[7:0] <= rx_data;
                        cmd_rdy  <= 1'b1;
                        state    <= HIGH;
                    end
`ifdef CMD_TMO_EN
                    else if (tmo_cnt == CW'(TMO_CYC - 1))
                        state <= HIGH;
                    else
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                end
                default: state <= HIGH;
            endcase
        end
    end

    // trmt counts as busy during its own pulse; tx_done frees the line at once.
    assign busy_eff = trmt | (tx_busy & ~tx_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trmt      <= 1'b0;
            tx_busy   <= 1'b0;
            resp_pend <= 1'b0;
        end else begin
            trmt <= 1'b0;
            if (trmt)
                tx_busy <= 1'b1;
            else if (tx_done)
                tx_busy <= 1'b0;
            if ((send_resp || resp_pend) && !busy_eff) begin
                trmt      <= 1'b1;
                resp_pend <= 1'b0;
            end else if (send_resp) begin
                resp_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_framer.sv
// Self-checking bench for cmd_framer: directed framing/transmit/reset cases
// plus randomized byte pairs checked against a byte-queue reference.
module tb_cmd_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_clr = 0;
    int unsigned n_trmt = 0;
    int unsigned bytes_sent = 0;

    logic [7:0]  q[$];
    logic [15:0] exp_cmd;

    cmd_framer #(.TMO_CYC(16), .RESP_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_rx_rdy) n_clr <= n_clr + 1;
        if (trmt) n_trmt <= n_trmt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART receiver model: byte held until the consuming edge.
    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(negedge clk);
        rx_data = b;
        rx_rdy = 1'b1;
        clr_cmd_rdy = clr;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        bytes_sent++;
    endtask

    task automatic pulse_send_resp();
        @(negedge clk);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_cmd", 32'(cmd), 32'h0000);
        check("rst_cmd_rdy", 32'(cmd_rdy), 0);
        check("rst_trmt", 32'(trmt), 0);
        check("rst_clr_rx", 32'(clr_rx_rdy), 0);
        check("rst_tx_data", 32'(tx_data), 32'hA5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic command framing
        send_byte(8'h20, 1'b0);
        check("hi_cmd_rdy", 32'(cmd_rdy), 0);
        send_byte(8'h3F, 1'b0);
        check("cmd_203f", 32'(cmd), 32'h203F);
        check("rdy_203f", 32'(cmd_rdy), 1);
        check("clr_pulses2", n_clr, 2);
        repeat (3) @(negedge clk);
        check("rdy_held", 32'(cmd_rdy), 1);

        // Consumer clear, then new high byte
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("rdy_cleared", 32'(cmd_rdy), 0);
        send_byte(8'h40, 1'b0);
        check("hi_40", 32'(cmd[15:8]), 32'h40);
        repeat (3) @(negedge clk);
        check("rdy_wait_lo", 32'(cmd_rdy), 0);
        send_byte(8'h11, 1'b1);
        check("cmd_4011", 32'(cmd), 32'h4011);
        check("set_wins", 32'(cmd_rdy), 1);

        // Transmit: idle request, then one queued behind busy
        pulse_send_resp();
        check("trmt_idle", 32'(trmt), 1);
        check("tx_data", 32'(tx_data), 32'hA5);
        @(negedge clk);
        check("trmt_pulse_1cyc", 32'(trmt), 0);
        pulse_send_resp();
        repeat (3) @(negedge clk);
        check("no_trmt_busy", n_trmt, 1);
        pulse_tx_done();
        check("trmt_after_done", 32'(trmt), 1);
        @(negedge clk);
        check("trmt_count2", n_trmt, 2);

        // Several requests while busy collapse into one
        repeat (3) pulse_send_resp();
        repeat (2) @(negedge clk);
        check("no_trmt_busy2", n_trmt, 2);
        pulse_tx_done();
        check("trmt_collapsed", 32'(trmt), 1);
        repeat (2) @(negedge clk);
        pulse_tx_done();
        repeat (3) @(negedge clk);
        check("trmt_count3", n_trmt, 3);

        // send_resp coincident with tx_done
        pulse_send_resp();
        @(negedge clk);
        check("trmt_count4", n_trmt, 4);
        tx_done = 1'b1;
        send_resp = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        send_resp = 1'b0;
        check("trmt_coincident", 32'(trmt), 1);
        @(negedge clk);
        check("trmt_count5", n_trmt, 5);
        pulse_tx_done();

        // Reset mid-command discards the high byte
        send_byte(8'h41, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", 32'(cmd), 32'h0000);
        check("midrst_rdy", 32'(cmd_rdy), 0);
        check("midrst_trmt", 32'(trmt), 0);
        check("midrst_tx_data", 32'(tx_data), 32'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        check("cmd_0005", 32'(cmd), 32'h0005);
        check("rdy_0005", 32'(cmd_rdy), 1);

        // Inter-byte gap of 20 clocks
        send_byte(8'h41, 1'b0);
        repeat (20) @(negedge clk);
        check("gap_hi_kept", 32'(cmd[15:8]), 32'h41);
        check("gap_no_rdy", 32'(cmd_rdy), 0);
`ifdef CMD_TMO_EN
        send_byte(8'h60, 1'b0);
        check("tmo_new_hi_rdy", 32'(cmd_rdy), 0);
        send_byte(8'h01, 1'b0);
        check("cmd_6001", 32'(cmd), 32'h6001);
        check("rdy_6001", 32'(cmd_rdy), 1);
`else
        send_byte(8'h60, 1'b0);
        check("cmd_4160", 32'(cmd), 32'h4160);
        check("rdy_4160", 32'(cmd_rdy), 1);
`endif

        // Randomized pairs against a byte-queue reference
        for (int k = 0; k < 40; k++) begin
            logic [7:0] hi;
            logic [7:0] lo;
            logic       clr;
            hi = 8'($urandom);
            lo = 8'($urandom);
            clr = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            q.push_back(hi);
            send_byte(hi, clr);
            check("rand_hi_rdy", 32'(cmd_rdy), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            q.push_back(lo);
            send_byte(lo, clr);
            exp_cmd = {q[0], q[1]};
            q.delete();
            check("rand_cmd", 32'(cmd), 32'(exp_cmd));
            check("rand_rdy", 32'(cmd_rdy), 1);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                check("rand_clr", 32'(cmd_rdy), 0);
                check("rand_cmd_stable", 32'(cmd), 32'(exp_cmd));
            end
        end

        @(negedge clk);
        check("clr_pulse_total", n_clr, bytes_sent);
        check("trmt_total", n_trmt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_framer.md
CMD_FRAMER -- requirements
Module: cmd_framer

Interface
REQ-001 Parameter TMO_CYC, default 1_000_000, inter-byte timeout in clk cycles (used only with CMD_TMO_EN).
REQ-002 Parameter RESP_BYTE, default 8'hA5, acknowledge byte transmitted on send_resp.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_data  input  8  byte from UART receiver; valid while rx_rdy=1.
REQ-006 rx_rdy  input  1  UART receiver byte-available flag; held until clr_rx_rdy.
REQ-007 clr_rx_rdy  output  1  one-cycle pulse consuming the current rx byte.
REQ-008 trmt  output  1  one-cycle pulse starting a UART transmit of tx_data.
REQ-009 tx_data  output  8  byte to transmit; constant RESP_BYTE.
REQ-010 tx_done  input  1  UART transmitter finished flag.
REQ-011 cmd  output  16  assembled command word, {high byte, low byte}.
REQ-012 cmd_rdy  output  1  level flag: complete command word available on cmd.
REQ-013 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-014 send_resp  input  1  one-cycle request to transmit RESP_BYTE.

Function
REQ-015 Receive FSM has states HIGH and LOW; reset state HIGH.
REQ-016 In HIGH with rx_rdy=1: capture rx_data into cmd[15:8], pulse clr_rx_rdy that cycle, clear cmd_rdy on the next edge, go to LOW.
REQ-017 In LOW with rx_rdy=1: capture rx_data into cmd[7:0], pulse clr_rx_rdy that cycle, set cmd_rdy on the next edge, go to HIGH.
REQ-018 cmd_rdy rises one clk after the clr_rx_rdy pulse of the low byte; cmd is stable from that edge until the next high byte is captured.
REQ-019 clr_cmd_rdy clears cmd_rdy on the next edge; if clr_cmd_rdy and the low-byte completion coincide, set wins (cmd_rdy=1).
REQ-020 clr_rx_rdy is asserted at most once per received byte; no byte is consumed while rx_rdy=0.
REQ-021 Transmit side: tx_busy flag set on trmt, cleared on tx_done; trmt never asserts while tx_busy=1.
REQ-022 send_resp with tx_busy=0 and no pending request: trmt pulses in the cycle after send_resp.
REQ-023 send_resp with tx_busy=1: set resp_pend; trmt pulses in the cycle after tx_busy clears; resp_pend then clears.
REQ-024 Multiple send_resp while a response is pending collapse into one pending response (depth 1).
REQ-025 send_resp coincident with tx_done: treated as busy-clear first; trmt issues on the next cycle.
REQ-026 Receive and transmit paths operate independently and concurrently.

Reset
REQ-027 On rst_n=0, asynchronously: FSM=HIGH, cmd=16'h0000, cmd_rdy=0, clr_rx_rdy=0, trmt=0, tx_busy=0, resp_pend=0, timeout counter=0.
REQ-028 Reset asserted mid-command (in LOW) discards the partial high byte; after release the next received byte is treated as a high byte.
REQ-029 tx_data=RESP_BYTE at all times, including during reset.

Configuration
REQ-030 Macro CMD_TMO_EN defined: in LOW a counter increments each clk, resets on entry to LOW; on reaching TMO_CYC-1 without rx_rdy the FSM returns to HIGH, cmd[15:8] is retained but cmd_rdy is not set.
REQ-031 CMD_TMO_EN undefined: no counter is instantiated; LOW waits indefinitely for the low byte.

Verification
REQ-032 Bytes 8'h20 then 8'h3F, clr_cmd_rdy idle -> clr_rx_rdy pulses twice, cmd=16'h203F, cmd_rdy=1 one clk after the second pulse, held high.
REQ-033 cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next edge; new high byte 8'h40 -> cmd[15:8]=8'h40, cmd_rdy remains 0 until the low byte.
REQ-034 send_resp with tx idle -> trmt pulse next cycle, tx_data=8'hA5; second send_resp before tx_done -> exactly one more trmt, the cycle after tx_done.
REQ-035 High byte 8'h41, then rst_n pulsed low, then bytes 8'h00, 8'h05 -> cmd=16'h0005, cmd_rdy=1.
REQ-036 CMD_TMO_EN, TMO_CYC=16: high byte 8'h41, no byte for 20 clks, then bytes 8'h60, 8'h01 -> cmd=16'h6001, cmd_rdy=1, no cmd_rdy before.
REQ-037 Low-byte completion in the same cycle as clr_cmd_rdy -> cmd_rdy=1 after the edge.
